// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: access size codes, FSM states,
// default ack timeout and the natural-alignment rule.
package mem_access_stage_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // funct3 load codes; stores use the same low two bits for size
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (off[0] == 1'b0);
      SZ_W:    ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
interface mem_access_stage_if #(
  parameter int unsigned DATA_W = 64
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [DATA_W-1:0]     dmem_addr;
  logic [DATA_W-1:0]     dmem_wdata;
  logic [DATA_W/8-1:0]   dmem_be;
  logic                  dmem_ack;
  logic [DATA_W-1:0]     dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                  input  dmem_ack, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                  output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed lane of a read doubleword and sign/zero extends it by funct3.
module mem_load_align
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        offset,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] lane;

  always_comb begin
    lane = rdata >> {offset, 3'b000};
    data = lane;
    case (funct3)
      F3_LB:   data = {{(DATA_W-8){lane[7]}},   lane[7:0]};
      F3_LH:   data = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      F3_LW:   data = {{(DATA_W-32){lane[31]}}, lane[31:0]};
      F3_LBU:  data = {{(DATA_W-8){1'b0}},      lane[7:0]};
      F3_LHU:  data = {{(DATA_W-16){1'b0}},     lane[15:0]};
      F3_LWU:  data = {{(DATA_W-32){1'b0}},     lane[31:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues one data-memory access per load/store, stalls until
// ack or timeout, and drives the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_memRead,
  input  logic                i_memWrite,
  input  logic                i_memToReg,
  input  logic                i_regWrite,
  input  logic [DATA_W-1:0]   i_alu_out,
  input  logic [DATA_W-1:0]   i_rs2_data,
  input  logic [4:0]          i_rd_addr,
  input  logic [31:0]         i_inst,
  output logic                o_stall,
  mem_access_stage_if.master  dmem,
  output logic                o_regWrite,
  output logic                o_memToReg,
  output logic [4:0]          o_rd_addr,
  output logic [DATA_W-1:0]   o_alu_out,
  output logic [DATA_W-1:0]   o_mem_data,
  output logic [31:0]         o_inst,
  output logic                o_fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BE_W  = DATA_W / 8;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  busy_cnt;
  logic              mem_op, aligned, expire;
  logic              start, misalign, done, abort;

  logic              lat_regWrite, lat_memToReg, lat_write;
  logic [4:0]        lat_rd;
  logic [DATA_W-1:0] lat_alu;
  logic [31:0]       lat_inst;

  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] load_data;

  assign mem_op  = i_memRead | i_memWrite;
  assign aligned = is_aligned(i_inst[13:12], i_alu_out[2:0]);
  assign expire  = (busy_cnt == CNT_W'(TIMEOUT - 1));

  assign dmem.dmem_req   = (state == ST_BUSY);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_stall   = 1'b0;
    start     = 1'b0;
    misalign  = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op && aligned) begin
          start     = 1'b1;
          o_stall   = 1'b1;
          state_nxt = ST_BUSY;
        end else if (mem_op) begin
          misalign  = 1'b1;
        end
      end
      ST_BUSY: begin
        // ack takes priority over an expiring counter in the same cycle
        if (dmem.dmem_ack) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (expire) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          o_stall   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (i_rst) o_stall = 1'b0;
  end

  mem_load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata  (dmem.dmem_rdata),
    .offset (lat_alu[2:0]),
    .funct3 (lat_inst[14:12]),
    .data   (load_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_cnt     <= '0;
      lat_regWrite <= 1'b0;
      lat_memToReg <= 1'b0;
      lat_write    <= 1'b0;
      lat_rd       <= '0;
      lat_alu      <= '0;
      lat_inst     <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      o_regWrite   <= 1'b0;
      o_memToReg   <= 1'b0;
      o_rd_addr    <= '0;
      o_alu_out    <= '0;
      o_mem_data   <= '0;
      o_inst       <= '0;
      o_fault      <= 1'b0;
    end else begin
      o_fault <= misalign | abort;
      if (state == ST_BUSY) busy_cnt <= busy_cnt + 1'b1;
      if (start) begin
        busy_cnt     <= '0;
        lat_regWrite <= i_regWrite;
        lat_memToReg <= i_memToReg;
        lat_write    <= i_memWrite;
        lat_rd       <= i_rd_addr;
        lat_alu      <= i_alu_out;
        lat_inst     <= i_inst;
        we_q         <= i_memWrite;
        addr_q       <= {i_alu_out[DATA_W-1:3], 3'b000};
        wdata_q      <= i_rs2_data << {i_alu_out[2:0], 3'b000};
        be_q         <= BE_W'(size_mask(i_inst[13:12])) << i_alu_out[2:0];
      end
      if (state == ST_IDLE && !mem_op) begin
        o_regWrite <= i_regWrite;
        o_memToReg <= i_memToReg;
        o_rd_addr  <= i_rd_addr;
        o_alu_out  <= i_alu_out;
        o_mem_data <= '0;
        o_inst     <= i_inst;
      end else if (start || misalign || abort) begin
        o_regWrite <= 1'b0;
        o_memToReg <= 1'b0;
        o_rd_addr  <= '0;
      end else if (done) begin
        o_regWrite <= lat_regWrite & ~lat_write;
        o_memToReg <= lat_memToReg;
        o_rd_addr  <= lat_rd;
        o_alu_out  <= lat_alu;
        o_mem_data <= lat_write ? '0 : load_data;
        o_inst     <= lat_inst;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed corner cases plus random
// loads/stores checked against a byte-level reference model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TMO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_memRead, i_memWrite, i_memToReg, i_regWrite;
  logic [63:0] i_alu_out, i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_inst;
  logic        o_stall, o_regWrite, o_memToReg, o_fault;
  logic [4:0]  o_rd_addr;
  logic [63:0] o_alu_out, o_mem_data;
  logic [31:0] o_inst;

  int checks = 0;
  int failures = 0;

  mem_access_stage_if #(.DATA_W(64)) dmem ();

  mem_access_stage #(.DATA_W(64), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite),
    .i_memToReg(i_memToReg), .i_regWrite(i_regWrite),
    .i_alu_out(i_alu_out), .i_rs2_data(i_rs2_data),
    .i_rd_addr(i_rd_addr), .i_inst(i_inst),
    .o_stall(o_stall), .dmem(dmem.master),
    .o_regWrite(o_regWrite), .o_memToReg(o_memToReg),
    .o_rd_addr(o_rd_addr), .o_alu_out(o_alu_out),
    .o_mem_data(o_mem_data), .o_inst(o_inst), .o_fault(o_fault)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: byte-by-byte view of memory lanes
  function automatic int nbytes_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off, input logic [2:0] f3);
    logic [63:0] v;
    int n;
    n = nbytes_of(f3);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_be(input int off, input logic [2:0] f3);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < nbytes_of(f3); i++) b[off+i] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] rs2, input int off);
    logic [63:0] w;
    w = '0;
    for (int i = off; i < 8; i++) w[8*i +: 8] = rs2[8*(i-off) +: 8];
    return w;
  endfunction

  task automatic drive_idle();
    i_memRead = 0; i_memWrite = 0; i_memToReg = 0; i_regWrite = 0;
    i_alu_out = '0; i_rs2_data = '0; i_rd_addr = '0; i_inst = '0;
    dmem.dmem_ack = 0; dmem.dmem_rdata = '0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    drive_idle();
    i_memRead = 1'b1;
    #12;
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", o_stall); end
    checks++; if (dmem.dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", dmem.dmem_req); end
    checks++; if (o_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b want=0", o_fault); end
    checks++; if ({o_regWrite, o_memToReg, o_rd_addr, o_alu_out, o_mem_data, o_inst} !== '0) begin
      failures++; $display("FAIL reset_memwb got nonzero alu=%h mem=%h", o_alu_out, o_mem_data); end
    drive_idle();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic alu_op(input logic rw, input logic m2r, input logic [4:0] rd, input logic [63:0] alu, input logic [31:0] inst);
    i_memRead = 0; i_memWrite = 0; i_regWrite = rw; i_memToReg = m2r;
    i_rd_addr = rd; i_alu_out = alu; i_inst = inst; i_rs2_data = {$urandom, $urandom};
    #1;
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b want=0", o_stall); end
    @(posedge i_clk); #1;
    checks++; if (o_alu_out !== alu) begin failures++; $display("FAIL alu_out got=%h want=%h", o_alu_out, alu); end
    checks++; if (o_rd_addr !== rd) begin failures++; $display("FAIL alu_rd got=%0d want=%0d", o_rd_addr, rd); end
    checks++; if ({o_regWrite, o_memToReg} !== {rw, m2r}) begin
      failures++; $display("FAIL alu_ctl got=%b%b want=%b%b", o_regWrite, o_memToReg, rw, m2r); end
    checks++; if (o_inst !== inst) begin failures++; $display("FAIL alu_inst got=%h want=%h", o_inst, inst); end
    checks++; if (o_mem_data !== 64'd0) begin failures++; $display("FAIL alu_memdata got=%h want=0", o_mem_data); end
  endtask

  task automatic test_alu_op();
    alu_op(1'b1, 1'b0, 5'd5, 64'h2A, 32'h0000_0033);
    for (int n = 0; n < 6; n++)
      alu_op(1'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom}, $urandom);
    drive_idle();
  endtask

  // ack_at: BUSY cycle (1-based) on which ack arrives; 0 means never
  task automatic run_mem_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] rs2, input logic [63:0] rdata,
                            input int ack_at, input logic [4:0] rd, input logic rw, input logic m2r);
    int off;
    logic ok, completes, ack;
    logic [31:0] inst;
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_be;
    off = int'(addr[2:0]);
    ok = (off % nbytes_of(f3)) == 0;
    completes = (ack_at >= 1 && ack_at <= TMO);
    exp_addr = addr & ~64'h7;
    exp_be = model_be(off, f3);
    exp_wdata = model_wdata(rs2, off);
    inst = $urandom;
    inst[14:12] = f3;
    i_memRead = rd_en; i_memWrite = wr_en; i_regWrite = rw; i_memToReg = m2r;
    i_rd_addr = rd; i_alu_out = addr; i_rs2_data = rs2; i_inst = inst;
    #1;
    checks++; if (o_stall !== ok) begin failures++; $display("FAIL op_idle_stall got=%b want=%b", o_stall, ok); end
    checks++; if (dmem.dmem_req !== 1'b0) begin failures++; $display("FAIL op_idle_req got=%b want=0", dmem.dmem_req); end
    if (!ok) begin
      @(posedge i_clk); #1;
      checks++; if (o_fault !== 1'b1) begin failures++; $display("FAIL misalign_fault got=%b want=1", o_fault); end
      checks++; if (dmem.dmem_req !== 1'b0) begin failures++; $display("FAIL misalign_req got=%b want=0", dmem.dmem_req); end
      checks++; if ({o_regWrite, o_memToReg, o_rd_addr} !== 7'd0) begin
        failures++; $display("FAIL misalign_bubble got rw=%b rd=%0d want 0", o_regWrite, o_rd_addr); end
      drive_idle();
      @(posedge i_clk); #1;
      checks++; if (o_fault !== 1'b0) begin failures++; $display("FAIL misalign_pulse got=%b want=0", o_fault); end
      return;
    end
    for (int k = 1; k <= TMO; k++) begin
      @(posedge i_clk); #1;
      checks++; if (dmem.dmem_req !== 1'b1) begin failures++; $display("FAIL busy_req c%0d got=%b want=1", k, dmem.dmem_req); end
      checks++; if ({dmem.dmem_we, dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata} !== {wr_en, exp_addr, exp_be, exp_wdata}) begin
        failures++; $display("FAIL busy_bus c%0d got we=%b a=%h be=%h wd=%h want we=%b a=%h be=%h wd=%h", k,
          dmem.dmem_we, dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata, wr_en, exp_addr, exp_be, exp_wdata); end
      if (k == 1) begin
        checks++; if ({o_regWrite, o_memToReg, o_rd_addr} !== 7'd0) begin
          failures++; $display("FAIL busy_bubble got rw=%b rd=%0d want 0", o_regWrite, o_rd_addr); end
      end
      ack = (k == ack_at);
      dmem.dmem_ack = ack;
      dmem.dmem_rdata = ack ? rdata : {$urandom, $urandom};
      #1;
      checks++; if (o_stall !== !(ack || k == TMO)) begin
        failures++; $display("FAIL busy_stall c%0d got=%b want=%b", k, o_stall, !(ack || k == TMO)); end
      if (ack || k == TMO) break;
    end
    @(posedge i_clk); #1;
    dmem.dmem_ack = 1'b0;
    checks++; if (dmem.dmem_req !== 1'b0) begin failures++; $display("FAIL end_req got=%b want=0", dmem.dmem_req); end
    if (completes) begin
      checks++; if (o_fault !== 1'b0) begin failures++; $display("FAIL done_fault got=%b want=0", o_fault); end
      checks++; if ({o_regWrite, o_memToReg, o_rd_addr} !== {rw & ~wr_en, m2r, rd}) begin
        failures++; $display("FAIL done_ctl got rw=%b m2r=%b rd=%0d want rw=%b m2r=%b rd=%0d",
          o_regWrite, o_memToReg, o_rd_addr, rw & ~wr_en, m2r, rd); end
      checks++; if ({o_alu_out, o_inst} !== {addr, inst}) begin
        failures++; $display("FAIL done_fields got alu=%h inst=%h want alu=%h inst=%h", o_alu_out, o_inst, addr, inst); end
      checks++; if (o_mem_data !== (wr_en ? 64'd0 : model_load(rdata, off, f3))) begin
        failures++; $display("FAIL done_memdata got=%h want=%h", o_mem_data, wr_en ? 64'd0 : model_load(rdata, off, f3)); end
      drive_idle();
    end else begin
      checks++; if (o_fault !== 1'b1) begin failures++; $display("FAIL timeout_fault got=%b want=1", o_fault); end
      checks++; if ({o_regWrite, o_memToReg, o_rd_addr} !== 7'd0) begin
        failures++; $display("FAIL timeout_bubble got rw=%b rd=%0d want 0", o_regWrite, o_rd_addr); end
      drive_idle();
      @(posedge i_clk); #1;
      checks++; if (o_fault !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b want=0", o_fault); end
    end
  endtask

  task automatic test_directed();
    run_mem_op(1, 0, F3_LB, 64'h1003, 64'h0, 64'h00000000_80000000, 1, 5'd7, 1, 1);
    checks++; if (o_mem_data !== 64'hFFFFFFFF_FFFFFF80) begin
      failures++; $display("FAIL lb_data got=%h want=ffffffffffffff80", o_mem_data); end
    run_mem_op(0, 1, 3'b001, 64'h2006, 64'hBEEF, 64'h0, 4, 5'd9, 1, 0);
    run_mem_op(1, 0, F3_LW, 64'h3002, 64'h0, 64'h0, 1, 5'd3, 1, 1);
  endtask

  task automatic test_timeout();
    run_mem_op(1, 0, F3_LD, 64'h4000, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 5'd11, 1, 1);
    run_mem_op(1, 0, F3_LD, 64'h4008, 64'h0, 64'hFEDC_BA98_7654_3210, TMO, 5'd12, 1, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic wr, both;
      logic [2:0] f3;
      logic [63:0] addr;
      wr = 1'($urandom);
      both = wr & 1'($urandom);
      f3 = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) addr[2:0] = addr[2:0] & ~3'(nbytes_of(f3) - 1);
      run_mem_op(!wr | both, wr, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(1, 5), 5'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_in_busy();
    run_reset_busy();
  endtask

  task automatic run_reset_busy();
    i_memRead = 1; i_memWrite = 0; i_regWrite = 1; i_memToReg = 1;
    i_rd_addr = 5'd21; i_alu_out = 64'h5000; i_inst = 32'h0000_3003;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    checks++; if (dmem.dmem_req !== 1'b1) begin failures++; $display("FAIL rstbusy_req_pre got=%b want=1", dmem.dmem_req); end
    i_rst = 1'b1;
    #1;
    checks++; if ({dmem.dmem_req, o_stall, o_fault} !== 3'b000) begin
      failures++; $display("FAIL rstbusy_async got req=%b stall=%b fault=%b want 000", dmem.dmem_req, o_stall, o_fault); end
    drive_idle();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    dmem.dmem_ack = 1'b1;
    dmem.dmem_rdata = 64'hAAAA_5555_AAAA_5555;
    #1;
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL rstbusy_stall got=%b want=0", o_stall); end
    @(posedge i_clk); #1;
    dmem.dmem_ack = 1'b0;
    checks++; if ({dmem.dmem_req, o_fault} !== 2'b00) begin
      failures++; $display("FAIL rstbusy_late_ack got req=%b fault=%b want 00", dmem.dmem_req, o_fault); end
    checks++; if ({o_regWrite, o_memToReg, o_rd_addr, o_mem_data} !== '0) begin
      failures++; $display("FAIL rstbusy_memwb got rw=%b rd=%0d data=%h want 0", o_regWrite, o_rd_addr, o_mem_data); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_directed();
    test_timeout();
    test_random();
    test_reset_in_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
